manchester_frame_ctrl: RTL and testbench

- Frame controller sitting directly downstream of the Manchester byte decoder.
- Hunts for a sync byte, then reads a length byte, forwards the payload as an AXI-Stream packet with tlast, and verifies a modulo-256 checksum trailer.
- Reports frame status and drives a resync reset back into the decoder after any error.

---
 rtl/manchester_frame_ctrl_if.sv | 12 +
 rtl/manchester_frame_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_manchester_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/manchester_frame_ctrl_if.sv
// Byte-wide AXI-Stream link on either side of the frame controller.
// The slave side only carries data/valid/ready; tlast/tuser flow downstream.
interface manchester_frame_ctrl_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, input tready, output tlast, output tuser);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/manchester_frame_ctrl.sv
// Frame controller behind the Manchester byte decoder: sync hunt, length,
// payload forwarding with tlast, checksum trailer, timeout and decoder resync.
module manchester_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hD5,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  manchester_frame_ctrl_if.slave  s_axis,
  manchester_frame_ctrl_if.master m_axis,
  output logic                    frame_ok,
  output logic                    frame_err,
  output logic [1:0]              err_code,
  output logic                    dec_resetn
);
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LIM   = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    LEN_MAX = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHK, FLUSH, RESYNC} state_t;

  state_t        state, state_nx;
  logic [7:0]    len, len_nx, sum, sum_nx, cnt, cnt_nx, hold, hold_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [7:0]    out_data, out_data_nx;
  logic          out_valid, out_valid_nx, out_last, out_last_nx, out_user, out_user_nx;
  logic          pend, pend_nx, pend_user, pend_user_nx;
  logic [7:0]    pend_data, pend_data_nx;
  logic          bad, bad_nx, rs_cnt, rs_nx;
  logic          ok_nx, err_nx, dec_nx;
  logic [1:0]    code_nx;
  logic          s_ready, acc, out_free, counting, expire;
  logic          term, term_user, load, load_last, load_user;
  logic [7:0]    term_data, load_data;

  assign out_free = !out_valid || m_axis.tready;
  assign s_ready  = (state == HUNT) || (state == LEN) || (state == CHK) ||
                    ((state == PAYLOAD) && out_free);
  assign acc      = s_axis.tvalid && s_ready;
  assign counting = (state == LEN) || (state == PAYLOAD) || (state == CHK);
  // An accepted byte in the expiry cycle wins over the timeout.
  assign expire   = counting && (timer == T_LIM) && !acc;

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = out_data;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast  = out_last;
  assign m_axis.tuser  = out_user;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= HUNT;
      len        <= 8'h00;
      sum        <= 8'h00;
      cnt        <= 8'h00;
      hold       <= 8'h00;
      timer      <= '0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_user   <= 1'b0;
      pend       <= 1'b0;
      pend_data  <= 8'h00;
      pend_user  <= 1'b0;
      bad        <= 1'b0;
      rs_cnt     <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'b00;
      dec_resetn <= 1'b1;
    end else begin
      state      <= state_nx;
      len        <= len_nx;
      sum        <= sum_nx;
      cnt        <= cnt_nx;
      hold       <= hold_nx;
      timer      <= timer_nx;
      out_data   <= out_data_nx;
      out_valid  <= out_valid_nx;
      out_last   <= out_last_nx;
      out_user   <= out_user_nx;
      pend       <= pend_nx;
      pend_data  <= pend_data_nx;
      pend_user  <= pend_user_nx;
      bad        <= bad_nx;
      rs_cnt     <= rs_nx;
      frame_ok   <= ok_nx;
      frame_err  <= err_nx;
      err_code   <= code_nx;
      dec_resetn <= dec_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    len_nx       = len;
    sum_nx       = sum;
    cnt_nx       = cnt;
    hold_nx      = hold;
    pend_nx      = pend;
    pend_data_nx = pend_data;
    pend_user_nx = pend_user;
    bad_nx       = bad;
    rs_nx        = rs_cnt;
    ok_nx        = 1'b0;
    err_nx       = 1'b0;
    code_nx      = err_code;
    term         = 1'b0;
    term_data    = 8'h00;
    term_user    = 1'b0;
    load         = 1'b0;
    load_data    = 8'h00;
    load_last    = 1'b0;
    load_user    = 1'b0;

    case (state)
      HUNT: begin
        if (acc && (s_axis.tdata == SYNC_BYTE)) state_nx = LEN;
      end
      LEN: begin
        if (acc) begin
          if ((s_axis.tdata == 8'h00) || (s_axis.tdata > LEN_MAX)) begin
            code_nx  = 2'b01;
            err_nx   = 1'b1;
            state_nx = RESYNC;
          end else begin
            len_nx   = s_axis.tdata;
            sum_nx   = s_axis.tdata;
            cnt_nx   = 8'h00;
            state_nx = PAYLOAD;
          end
        end else if (expire) begin
          code_nx  = 2'b11;
          err_nx   = 1'b1;
          state_nx = RESYNC;
        end
      end
      PAYLOAD: begin
        if (acc) begin
          sum_nx = sum + s_axis.tdata;
          cnt_nx = cnt + 8'd1;
          // The final payload byte waits in hold until the trailer decides tuser.
          if (cnt_nx == len) begin
            hold_nx  = s_axis.tdata;
            state_nx = CHK;
          end else begin
            load      = 1'b1;
            load_data = s_axis.tdata;
          end
        end else if (expire) begin
          code_nx = 2'b11;
          err_nx  = 1'b1;
          if (cnt != 8'h00) begin
            term      = 1'b1;
            term_data = 8'h00;
            term_user = 1'b1;
            bad_nx    = 1'b1;
          end else begin
            state_nx = RESYNC;
          end
        end
      end
      CHK: begin
        if (acc) begin
          term      = 1'b1;
          term_data = hold;
          term_user = (s_axis.tdata != sum);
          bad_nx    = (s_axis.tdata != sum);
          ok_nx     = (s_axis.tdata == sum);
          err_nx    = (s_axis.tdata != sum);
          code_nx   = (s_axis.tdata == sum) ? 2'b00 : 2'b10;
        end else if (expire) begin
          term      = 1'b1;
          term_data = hold;
          term_user = 1'b1;
          bad_nx    = 1'b1;
          code_nx   = 2'b11;
          err_nx    = 1'b1;
        end
      end
      FLUSH: begin
        if (pend) begin
          if (out_free) begin
            load      = 1'b1;
            load_data = pend_data;
            load_last = 1'b1;
            load_user = pend_user;
            pend_nx   = 1'b0;
          end
        end else if (out_free) begin
          state_nx = bad ? RESYNC : HUNT;
        end
      end
      RESYNC: begin
        if (rs_cnt) begin
          rs_nx    = 1'b0;
          state_nx = HUNT;
        end else begin
          rs_nx = 1'b1;
        end
      end
      default: state_nx = HUNT;
    endcase

    // A terminating beat parks in pend while an earlier beat is still stalled.
    if (term) begin
      state_nx = FLUSH;
      if (out_free) begin
        load      = 1'b1;
        load_data = term_data;
        load_last = 1'b1;
        load_user = term_user;
      end else begin
        pend_nx      = 1'b1;
        pend_data_nx = term_data;
        pend_user_nx = term_user;
      end
    end

    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_last_nx  = out_last;
    out_user_nx  = out_user;
    if (load) begin
      out_valid_nx = 1'b1;
      out_data_nx  = load_data;
      out_last_nx  = load_last;
      out_user_nx  = load_user;
    end else if (m_axis.tready) begin
      out_valid_nx = 1'b0;
    end

    timer_nx = (acc || expire || !counting) ? '0 : timer + TW'(1);
    dec_nx   = (state_nx != RESYNC);
  end
endmodule

// File: tb/tb_manchester_frame_ctrl.sv
// Self-checking bench for manchester_frame_ctrl: directed vector table,
// hand-written corner sequences and a randomized frame stream vs. a frame-level model.
module tb_manchester_frame_ctrl;
  localparam logic [7:0] SYNC = 8'hD5;
  localparam int         MAXL = 64;
  localparam int         TMO  = 32;

  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  nb;
    logic [3:0]  nbeats;
    logic [31:0] data;
    logic        user;
    logic [3:0]  ok;
    logic [3:0]  err;
    logic [1:0]  code;
    logic [3:0]  low;
  } vec_t;

  logic       aclk;
  logic       aresetn;
  logic       frame_ok, frame_err, dec_resetn;
  logic [1:0] err_code;
  logic       ready_drv = 1'b1;
  int         ready_mode = 0;

  manchester_frame_ctrl_if s_if();
  manchester_frame_ctrl_if m_if();

  manchester_frame_ctrl #(.SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis     (s_if),
    .m_axis     (m_if),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .dec_resetn (dec_resetn)
  );

  assign s_if.tlast  = 1'b0;
  assign s_if.tuser  = 1'b0;
  assign m_if.tready = ready_drv;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Sink readiness: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge aclk) begin
    #1;
    case (ready_mode)
      0:       ready_drv = 1'b1;
      1:       ready_drv = ($urandom_range(0, 3) != 0);
      default: ready_drv = 1'b0;
    endcase
  end

  logic [9:0] beat_q[$];
  int         ok_seen = 0, err_seen = 0, low_seen = 0, stab_errs = 0;
  logic       held = 1'b0;
  logic [9:0] held_beat = '0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      held <= 1'b0;
    end else begin
      if (held && (!m_if.tvalid || ({m_if.tuser, m_if.tlast, m_if.tdata} !== held_beat)))
        stab_errs <= stab_errs + 1;
      if (m_if.tvalid && m_if.tready) beat_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
      held      <= m_if.tvalid && !m_if.tready;
      held_beat <= {m_if.tuser, m_if.tlast, m_if.tdata};
      ok_seen   <= ok_seen + int'(frame_ok);
      err_seen  <= err_seen + int'(frame_err);
      low_seen  <= low_seen + int'(!dec_resetn);
    end
  end

  int   checks = 0, errors = 0;
  int   q_base, ok_base, err_base, low_base;
  vec_t vecs[8];
  logic [7:0] stim_q[$];
  logic [9:0] exp_q[$];
  int   exp_ok, exp_err, exp_low;
  logic [1:0] exp_code;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic markBase();
    q_base   = beat_q.size();
    ok_base  = ok_seen;
    err_base = err_seen;
    low_base = low_seen;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_if.tready) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout actual=stuck required=accepted byte=%0h", b);
    end else begin
      @(posedge aclk);
    end
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    markBase();
    for (int i = 0; i < int'(v.nb); i++) sendByte(v.bytes[63-8*i -: 8]);
    repeat (60) @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input int idx);
    vec_t v;
    logic [9:0] bt;
    v = vecs[idx];
    check($sformatf("v%0d_nbeats", idx), beat_q.size() - q_base, v.nbeats);
    for (int k = 0; k < int'(v.nbeats); k++) begin
      if (q_base + k < beat_q.size()) begin
        bt = beat_q[q_base + k];
        check($sformatf("v%0d_b%0d_data", idx, k), bt[7:0], v.data[31-8*k -: 8]);
        check($sformatf("v%0d_b%0d_last", idx, k), bt[8], k == int'(v.nbeats) - 1);
        if (k == int'(v.nbeats) - 1) check($sformatf("v%0d_user", idx), bt[9], v.user);
      end
    end
    check($sformatf("v%0d_ok", idx), ok_seen - ok_base, v.ok);
    check($sformatf("v%0d_err", idx), err_seen - err_base, v.err);
    check($sformatf("v%0d_code", idx), err_code, v.code);
    check($sformatf("v%0d_resync", idx), low_seen - low_base, v.low);
  endtask

  // Frame-level model: parse the byte stream directly into expected packets.
  task automatic modelFrames();
    int i, len, total;
    bit good;
    exp_q.delete();
    exp_ok = 0; exp_err = 0; exp_low = 0; exp_code = 2'b00;
    i = 0;
    while (i < stim_q.size()) begin
      if (stim_q[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      if (i >= stim_q.size()) break;
      len = int'(stim_q[i]);
      i++;
      if (len == 0 || len > MAXL) begin
        exp_err++; exp_code = 2'b01; exp_low += 2;
        continue;
      end
      if (i + len >= stim_q.size()) break;
      total = len;
      for (int k = 0; k < len; k++) total += int'(stim_q[i + k]);
      good = ((total % 256) == int'(stim_q[i + len]));
      for (int k = 0; k < len; k++)
        exp_q.push_back({(k == len - 1) && !good, k == len - 1, stim_q[i + k]});
      if (good) begin
        exp_ok++; exp_code = 2'b00;
      end else begin
        exp_err++; exp_code = 2'b10; exp_low += 2;
      end
      i += len + 1;
    end
  endtask

  initial begin
    int len, tot;
    logic [7:0] b;
    vecs[0] = '{bytes: 64'hD5031122_33690000, nb: 4'd6, nbeats: 4'd3, data: 32'h11223300, user: 1'b0, ok: 4'd1, err: 4'd0, code: 2'd0, low: 4'd0};
    vecs[1] = '{bytes: 64'hD502AA55_00000000, nb: 4'd5, nbeats: 4'd2, data: 32'hAA550000, user: 1'b1, ok: 4'd0, err: 4'd1, code: 2'd2, low: 4'd2};
    vecs[2] = '{bytes: 64'hD5000000_00000000, nb: 4'd2, nbeats: 4'd0, data: 32'h0, user: 1'b0, ok: 4'd0, err: 4'd1, code: 2'd1, low: 4'd2};
    vecs[3] = '{bytes: 64'hD5410000_00000000, nb: 4'd2, nbeats: 4'd0, data: 32'h0, user: 1'b0, ok: 4'd0, err: 4'd1, code: 2'd1, low: 4'd2};
    vecs[4] = '{bytes: 64'h00FFD501_7E7F0000, nb: 4'd6, nbeats: 4'd1, data: 32'h7E000000, user: 1'b0, ok: 4'd1, err: 4'd0, code: 2'd0, low: 4'd0};
    vecs[5] = '{bytes: 64'hD5040102_00000000, nb: 4'd4, nbeats: 4'd3, data: 32'h01020000, user: 1'b1, ok: 4'd0, err: 4'd1, code: 2'd3, low: 4'd2};
    vecs[6] = '{bytes: 64'hD5000000_00000000, nb: 4'd1, nbeats: 4'd0, data: 32'h0, user: 1'b0, ok: 4'd0, err: 4'd1, code: 2'd3, low: 4'd2};
    vecs[7] = '{bytes: 64'hD501D5D6_00000000, nb: 4'd4, nbeats: 4'd1, data: 32'hD5000000, user: 1'b0, ok: 4'd1, err: 4'd0, code: 2'd0, low: 4'd0};

    aresetn     = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    #15;
    check("rst_tvalid", m_if.tvalid, 1'b0);
    check("rst_tlast", m_if.tlast, 1'b0);
    check("rst_tuser", m_if.tuser, 1'b0);
    check("rst_tdata", m_if.tdata, 8'h00);
    check("rst_ok_err", {frame_ok, frame_err}, 2'b00);
    check("rst_code", err_code, 2'b00);
    check("rst_dec_resetn", dec_resetn, 1'b1);
    check("rst_s_tready", s_if.tready, 1'b1);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(i);
      checkOutput(i);
    end

    $display("[TB] hunt with stalled sink");
    ready_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    markBase();
    sendByte(8'h00); sendByte(8'hFF); sendByte(8'hD5);
    sendByte(8'h01); sendByte(8'h7E); sendByte(8'h7F);
    @(negedge aclk);
    check("bp_ok_pulse", frame_ok, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d", c), {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {3'b101, 8'h7E});
      @(negedge aclk);
    end
    ready_mode = 0;
    repeat (10) @(posedge aclk);
    #1;
    check("bp_nbeats", beat_q.size() - q_base, 1);
    if (beat_q.size() > q_base) check("bp_beat", beat_q[q_base], {2'b01, 8'h7E});
    check("bp_ok_count", ok_seen - ok_base, 1);
    check("bp_code", err_code, 2'b00);

    $display("[TB] byte arriving in the expiry cycle");
    markBase();
    sendByte(SYNC);
    repeat (TMO - 1) @(posedge aclk);
    #1;
    sendByte(8'h01); sendByte(8'h5A); sendByte(8'h5B);
    repeat (20) @(posedge aclk);
    #1;
    check("race_err", err_seen - err_base, 0);
    check("race_ok", ok_seen - ok_base, 1);
    check("race_nbeats", beat_q.size() - q_base, 1);
    if (beat_q.size() > q_base) check("race_beat", beat_q[q_base], {2'b01, 8'h5A});

    $display("[TB] async reset mid-payload");
    ready_mode = 2;
    repeat (2) @(posedge aclk);
    #1;
    sendByte(SYNC); sendByte(8'h05); sendByte(8'h01);
    #2;
    check("ar_pre_tvalid", m_if.tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("ar_tvalid", m_if.tvalid, 1'b0);
    check("ar_tlast", m_if.tlast, 1'b0);
    check("ar_s_tready", s_if.tready, 1'b1);
    @(negedge aclk);
    aresetn    = 1'b1;
    ready_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    applyStimulus(0);
    checkOutput(0);

    $display("[TB] randomized frames");
    ready_mode = 1;
    stim_q.delete();
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        stim_q.push_back((b == SYNC) ? 8'h00 : b);
      end
      stim_q.push_back(SYNC);
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = $urandom_range(MAXL + 1, 255);
        2:       len = MAXL;
        default: len = $urandom_range(1, MAXL);
      endcase
      stim_q.push_back(8'(len));
      if (len == 0 || len > MAXL) continue;
      tot = len;
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        stim_q.push_back(b);
        tot += int'(b);
      end
      if ($urandom_range(0, 3) == 0) tot += $urandom_range(1, 255);
      stim_q.push_back(8'(tot));
    end
    modelFrames();
    markBase();
    foreach (stim_q[i]) begin
      sendByte(stim_q[i]);
      repeat ($urandom_range(0, 2)) begin
        @(posedge aclk);
        #1;
      end
    end
    ready_mode = 0;
    repeat (100) @(posedge aclk);
    #1;
    check("rnd_nbeats", beat_q.size() - q_base, exp_q.size());
    foreach (exp_q[k]) begin
      if (q_base + k < beat_q.size()) check($sformatf("rnd_beat%0d", k), beat_q[q_base + k], exp_q[k]);
    end
    check("rnd_ok", ok_seen - ok_base, exp_ok);
    check("rnd_err", err_seen - err_base, exp_err);
    check("rnd_resync", low_seen - low_base, exp_low);
    if (exp_ok + exp_err > 0) check("rnd_code", err_code, exp_code);

    check("stability", stab_errs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
